// File: rtl/ipm_req_arbiter.sv
// Round-robin arbiter that shares a single ipm datapath between NUM_REQ requesters.
// It issues one operation at a time, has a watchdog, and returns the result over a valid/ready channel.
module ipm_req_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*3-1:0]    req_op_i,
  input  logic [NUM_REQ*32-1:0]   req_a_i,
  input  logic [NUM_REQ*32-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [31:0]             rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    ipm_en_o,
  output logic                    ipm_sel_o,
  output logic [2:0]              ipm_operator_o,
  output logic [31:0]             ipm_a_o,
  output logic [31:0]             ipm_b_o,
  input  logic [31:0]             ipm_result_i,
  input  logic                    ipm_valid_i
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W  = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC);

  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [SUM_W-1:0] NUM_SUM  = SUM_W'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                  en_q, en_d;
  logic                  sel_q, sel_d;
  logic [CNT_W-1:0]      wd_q, wd_d;

  logic [OP_W-1:0]       op_arr [NUM_REQ];
  logic [DATA_W-1:0]     a_arr  [NUM_REQ];
  logic [DATA_W-1:0]     b_arr  [NUM_REQ];

  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [SUM_W-1:0]      cand_sum;
  logic [IDX_W-1:0]      cand;

  // Split the flat request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      op_arr[i] = req_op_i[i*OP_W +: OP_W];
      a_arr[i]  = req_a_i[i*DATA_W +: DATA_W];
      b_arr[i]  = req_b_i[i*DATA_W +: DATA_W];
    end
  end

  // The first valid requester at or after the rr pointer wins; the search wraps around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand_sum = {1'b0, rr_q} + SUM_W'(i);
      if (cand_sum >= NUM_SUM) begin
        cand_sum = cand_sum - NUM_SUM;
      end
      cand = cand_sum[IDX_W-1:0];
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // The accept strobe is combinational so the requester sees it in the cycle it wins.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready_o[i] = (state_q == S_IDLE) && grant_found && (grant_idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    en_d        = en_q;
    sel_d       = sel_q;
    wd_d        = wd_q;

    unique case (state_q)
      S_IDLE: begin
        en_d  = 1'b0;
        sel_d = 1'b0;
        if (grant_found) begin
          owner_d = grant_idx;
          op_d    = op_arr[grant_idx];
          a_d     = a_arr[grant_idx];
          b_d     = b_arr[grant_idx];
          rr_d    = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
          en_d    = 1'b1;
          sel_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end

      // A valid left over from the previous operation may still be visible here, so it is ignored.
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (ipm_valid_i || (wd_q == WD_LAST)) begin
          rsp_data_d           = ipm_valid_i ? ipm_result_i : '0;
          rsp_err_d            = !ipm_valid_i;
          rsp_valid_d          = '0;
          rsp_valid_d[owner_q] = 1'b1;
          en_d                 = 1'b0;
          sel_d                = 1'b0;
          state_d              = S_RESP;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready_i[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= '0;
      en_q        <= 1'b0;
      sel_q       <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      en_q        <= en_d;
      sel_q       <= sel_d;
      wd_q        <= wd_d;
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  assign ipm_en_o       = en_q;
  assign ipm_sel_o      = sel_q;
  assign ipm_operator_o = op_q;
  assign ipm_a_o        = a_q;
  assign ipm_b_o        = b_q;

endmodule
